// File: rtl/fp_unpack_pkg.sv
// Shared types and format constants for the FP operand unpacker (package fp_wire).
package fp_wire;

  localparam int EXPO_W     = 14;
  localparam int MANT_W     = 54;
  localparam int SGL_EXP_W  = 8;
  localparam int DBL_EXP_W  = 11;
  localparam int SGL_FRAC_W = 23;
  localparam int DBL_FRAC_W = 52;

  localparam logic [1:0]  FMT_SINGLE    = 2'd0;
  localparam logic [1:0]  FMT_DOUBLE    = 2'd1;
  localparam logic [31:0] SGL_CANON_NAN = 32'h7FC0_0000;
  localparam logic [63:0] DBL_CANON_NAN = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLS  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  fmt;
  } fp_unpack_in_type;

  typedef struct packed {
    logic              sig;
    logic [EXPO_W-1:0] expo;
    logic [MANT_W-1:0] mant;
    logic              snan;
    logic              qnan;
    logic              inf;
    logic              zero;
  } fp_unpack_out_type;

  // fclass index -> one-hot vector
  function automatic logic [9:0] class_bit(input int unsigned idx);
    return 10'd1 << idx;
  endfunction

endpackage

// File: rtl/fp_unpack_if.sv
// Handshake and result bus of the FP operand unpacker; out_class exists only with FP_UNPACK_CLASS_EN.
interface fp_unpack_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [1:0]  in_fmt;
    logic        out_valid;
    logic        out_ready;
    logic        out_sig;
    logic [13:0] out_expo;
    logic [53:0] out_mant;
    logic        out_snan;
    logic        out_qnan;
    logic        out_inf;
    logic        out_zero;
`ifdef FP_UNPACK_CLASS_EN
    logic [9:0]  out_class;

    modport master (
        output in_valid, in_data, in_fmt, out_ready,
        input  in_ready, out_valid, out_sig, out_expo, out_mant,
        input  out_snan, out_qnan, out_inf, out_zero, out_class
    );
    modport slave (
        input  in_valid, in_data, in_fmt, out_ready,
        output in_ready, out_valid, out_sig, out_expo, out_mant,
        output out_snan, out_qnan, out_inf, out_zero, out_class
    );
`else
    modport master (
        output in_valid, in_data, in_fmt, out_ready,
        input  in_ready, out_valid, out_sig, out_expo, out_mant,
        input  out_snan, out_qnan, out_inf, out_zero
    );
    modport slave (
        input  in_valid, in_data, in_fmt, out_ready,
        output in_ready, out_valid, out_sig, out_expo, out_mant,
        output out_snan, out_qnan, out_inf, out_zero
    );
`endif
endinterface

// File: rtl/fp_unpack_lzc.sv
// Combinational 64-bit leading-zero counter (module fp_lzc); an all-zero input reports 63.
module fp_lzc (
    input  logic [63:0] a_i,
    output logic [5:0]  cnt_o
);
    logic found;

    always_comb begin
        cnt_o = 6'd63;
        found = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (!found && a_i[i]) begin
                cnt_o = 6'(63 - i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fp_unpack.sv
// FP operand unpacker: IDLE -> CLS -> (NORM) -> DONE, one operand in flight.
// Optional fclass output enabled by defining FP_UNPACK_CLASS_EN.
module fp_unpack
    import fp_wire::*;
(
    input  logic   clk,
    input  logic   rst,
    fp_unpack_if.slave io
);
    state_t            state_q, state_d;
    fp_unpack_in_type  in_q, in_d;
    fp_unpack_out_type res_q, res_d;
    logic [9:0]        class_q, class_d;

    logic              is_dbl, legal, sign, e_ones, e_zero, f_zero, f_top;
    logic [EXPO_W-1:0] expo_e;
    logic [51:0]       frac52;
    logic [5:0]        lz;

    // Singles are only legal when NaN-boxed in the upper word
    assign is_dbl = (in_q.fmt == FMT_DOUBLE);
    assign legal  = is_dbl | ((in_q.fmt == FMT_SINGLE) & (&in_q.data[63:32]));
    assign sign   = is_dbl ? in_q.data[63] : in_q.data[31];
    assign e_ones = is_dbl ? (&in_q.data[DBL_FRAC_W +: DBL_EXP_W])
                           : (&in_q.data[SGL_FRAC_W +: SGL_EXP_W]);
    assign e_zero = is_dbl ? ~(|in_q.data[DBL_FRAC_W +: DBL_EXP_W])
                           : ~(|in_q.data[SGL_FRAC_W +: SGL_EXP_W]);
    assign expo_e = is_dbl ? EXPO_W'(in_q.data[DBL_FRAC_W +: DBL_EXP_W])
                           : EXPO_W'(in_q.data[SGL_FRAC_W +: SGL_EXP_W]);
    assign frac52 = is_dbl ? in_q.data[DBL_FRAC_W-1:0]
                           : {in_q.data[SGL_FRAC_W-1:0], 29'd0};
    assign f_zero = ~(|frac52);
    assign f_top  = frac52[51];

    // Fraction is already left-justified in mant, so one counter serves both formats
    fp_lzc u_lzc (
        .a_i   ({res_q.mant[51:0], 12'd0}),
        .cnt_o (lz)
    );

    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        res_d   = res_q;
        class_d = class_q;
        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    in_d.data = io.in_data;
                    in_d.fmt  = io.in_fmt;
                    state_d   = CLS;
                end
            end
            CLS: begin
                res_d   = '0;
                class_d = '0;
                state_d = DONE;
                if (!legal) begin
                    res_d.qnan = 1'b1;
                    class_d    = class_bit(9);
                end else if (e_ones) begin
                    res_d.sig = sign;
                    if (f_zero) begin
                        res_d.inf = 1'b1;
                        class_d   = sign ? class_bit(0) : class_bit(7);
                    end else if (f_top) begin
                        res_d.qnan = 1'b1;
                        class_d    = class_bit(9);
                    end else begin
                        res_d.snan = 1'b1;
                        class_d    = class_bit(8);
                    end
                end else if (e_zero && f_zero) begin
                    res_d.sig  = sign;
                    res_d.zero = 1'b1;
                    class_d    = sign ? class_bit(3) : class_bit(4);
                end else if (e_zero) begin
                    res_d.sig  = sign;
                    res_d.mant = {2'b00, frac52};
                    class_d    = sign ? class_bit(2) : class_bit(5);
                    state_d    = NORM;
                end else begin
                    res_d.sig  = sign;
                    res_d.expo = expo_e;
                    res_d.mant = {2'b01, frac52};
                    class_d    = sign ? class_bit(1) : class_bit(6);
                end
            end
            NORM: begin
                res_d.mant = res_q.mant << ({1'b0, lz} + 7'd1);
                res_d.expo = 14'd0 - {8'd0, lz};
                state_d    = DONE;
            end
            DONE: begin
                if (io.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            class_q <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            class_q <= class_d;
        end
    end

    // Captured operand is data only; it is always rewritten before use
    always_ff @(posedge clk) begin
        in_q <= in_d;
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.out_sig   = res_q.sig;
    assign io.out_expo  = res_q.expo;
    assign io.out_mant  = res_q.mant;
    assign io.out_snan  = res_q.snan;
    assign io.out_qnan  = res_q.qnan;
    assign io.out_inf   = res_q.inf;
    assign io.out_zero  = res_q.zero;
`ifdef FP_UNPACK_CLASS_EN
    assign io.out_class = class_q;
`else
    logic unused_class;
    assign unused_class = ^class_q;
`endif
endmodule

// File: tb/tb_fp_unpack.sv
// Randomized bench for fp_unpack against a behavioural field-level model.
module tb_fp_unpack;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fp_unpack_if io ();
    fp_unpack dut (.clk(clk), .rst(rst), .io(io));

    typedef struct {
        logic        sig;
        logic [13:0] expo;
        logic [53:0] mant;
        logic        snan, qnan, inf, zero;
        logic [9:0]  cls;
        int          lat;
    } exp_t;

    exp_t exp_cur;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, want);
        end
    endtask

    // Field-level reference: decode by format widths with plain integer arithmetic
    function automatic exp_t model(input logic [63:0] d, input logic [1:0] f);
        exp_t r;
        int ew, fw, msb;
        longint unsigned e, fr;
        bit s;
        r = '{sig: 0, expo: 0, mant: 0, snan: 0, qnan: 0, inf: 0, zero: 0, cls: 0, lat: 2};
        if (f == 2'd1) begin
            ew = 11; fw = 52; e = longint'(d[62:52]); fr = longint'(d[51:0]); s = d[63];
        end else if (f == 2'd0 && d[63:32] == 32'hFFFF_FFFF) begin
            ew = 8; fw = 23; e = longint'(d[30:23]); fr = longint'(d[22:0]); s = d[31];
        end else begin
            r.qnan = 1; r.cls = 10'd1 << 9;
            return r;
        end
        r.sig = s;
        if (e == (64'd1 << ew) - 1) begin
            if (fr == 0) begin r.inf = 1; r.cls = s ? 10'd1 : 10'd1 << 7; end
            else if (((fr >> (fw - 1)) & 1) == 1) begin r.qnan = 1; r.cls = 10'd1 << 9; end
            else begin r.snan = 1; r.cls = 10'd1 << 8; end
        end else if (e == 0 && fr == 0) begin
            r.zero = 1; r.cls = s ? 10'd1 << 3 : 10'd1 << 4;
        end else if (e == 0) begin
            msb = 0;
            for (int i = 0; i < 64; i++) if (((fr >> i) & 1) == 1) msb = i;
            r.mant = 54'(fr << (52 - msb));
            r.expo = 14'(msb - (fw - 1));
            r.lat  = 3;
            r.cls  = s ? 10'd1 << 2 : 10'd1 << 5;
        end else begin
            r.expo = 14'(e);
            r.mant = 54'((64'd1 << 52) | (fr << (52 - fw)));
            r.cls  = s ? 10'd1 << 1 : 10'd1 << 6;
        end
        return r;
    endfunction

    // Compare process: every cycle a result is held, it must equal the model
    always @(negedge clk) begin
        if (!rst) begin
            if (io.in_ready && io.out_valid) chk("ready_and_valid", 1, 0);
            if (io.out_valid) begin
                chk("sig",  io.out_sig,  exp_cur.sig);
                chk("expo", io.out_expo, exp_cur.expo);
                chk("mant", io.out_mant, exp_cur.mant);
                chk("flags", {io.out_snan, io.out_qnan, io.out_inf, io.out_zero},
                    {exp_cur.snan, exp_cur.qnan, exp_cur.inf, exp_cur.zero});
`ifdef FP_UNPACK_CLASS_EN
                chk("class", io.out_class, exp_cur.cls);
`endif
            end
        end
    end

    task automatic do_op(input logic [63:0] d, input logic [1:0] f, input int hold);
        int n;
        @(negedge clk);
        io.in_data = d; io.in_fmt = f; io.in_valid = 1'b1; io.out_ready = 1'b0;
        n = 0;
        while (!io.in_ready && n < 10) begin @(negedge clk); n++; end
        chk("in_ready_wait", io.in_ready, 1);
        exp_cur = model(d, f);
        @(posedge clk);
        @(negedge clk);
        io.in_valid = 1'b0;
        io.in_data  = {$urandom, $urandom};
        io.in_fmt   = 2'($urandom);
        n = 1;
        while (!io.out_valid && n < 8) begin @(negedge clk); n++; end
        chk("latency", 64'(n), 64'(exp_cur.lat));
        for (int i = 0; i < hold; i++) begin
            chk("in_ready_hold", io.in_ready, 0);
            @(negedge clk);
        end
        io.out_ready = 1'b1;
        @(negedge clk);
        io.out_ready = 1'b0;
        chk("in_ready_after", io.in_ready, 1);
        chk("valid_after", io.out_valid, 0);
    endtask

    function automatic logic [63:0] rand_operand(output logic [1:0] f);
        int ek, fk;
        logic [63:0] fr;
        logic [10:0] e;
        logic s;
        ek = $urandom_range(0, 3);
        fk = $urandom_range(0, 2);
        s  = 1'($urandom);
        fr = (fk == 0) ? 64'd0 : (fk == 1) ? (64'd1 << $urandom_range(0, 51)) : {$urandom, $urandom};
        e  = (ek == 0) ? 11'd0 : (ek == 1) ? 11'h7FF : 11'($urandom);
        case ($urandom_range(0, 9))
            0: begin f = 2'($urandom_range(2, 3)); return {$urandom, $urandom}; end
            1: begin f = 2'd0; return {$urandom | 32'h1, s, e[7:0], fr[22:0]} & 64'hFFFF_FFFE_FFFF_FFFF; end
            2, 3, 4: begin f = 2'd0; return {32'hFFFF_FFFF, s, e[7:0], fr[22:0]}; end
            default: begin f = 2'd1; return {s, e, fr[51:0]}; end
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        exp_t m;
        logic [63:0] d;
        logic [1:0]  f;
        io.in_valid = 0; io.in_data = '0; io.in_fmt = '0; io.out_ready = 0;
        exp_cur = model(64'd0, 2'd1);
        #3;
        chk("rst_in_ready", io.in_ready, 1);
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_mant", io.out_mant, 0);
        chk("rst_expo", io.out_expo, 0);
        @(negedge clk); rst = 1'b0;

        // Hand-computed pins on the model
        m = model(64'h3FF0_0000_0000_0000, 2'd1);
        chk("pin_norm_expo", m.expo, 14'h3FF);
        chk("pin_norm_mant", m.mant, 54'd1 << 52);
        m = model(64'hFFFF_FFFF_0000_0001, 2'd0);
        chk("pin_sub_expo", m.expo, 14'h3FEA);
        chk("pin_sub_mant", m.mant, 54'd1 << 52);
        chk("pin_sub_cls", m.cls, 10'h020);
        m = model(64'h7FF0_0000_0000_0001, 2'd1);
        chk("pin_snan", {m.snan, m.cls}, {1'b1, 10'h100});

        do_op(64'h3FF0_0000_0000_0000, 2'd1, 0);
        do_op(64'hFFFF_FFFF_0000_0001, 2'd0, 0);
        do_op(64'h0000_0000_4000_0000, 2'd0, 0);
        do_op(64'h3FF0_0000_0000_0000, 2'd2, 0);
        do_op(64'h7FF0_0000_0000_0001, 2'd1, 0);
        do_op(64'hFFF0_0000_0000_0000, 2'd1, 0);
        do_op(64'h8000_0000_0000_0000, 2'd1, 0);
        do_op(64'h0000_0000_0000_0001, 2'd1, 5);
        do_op(64'hFFFF_FFFF_7F80_0000, 2'd0, 5);

        // Reset while a subnormal sits in NORM
        @(negedge clk);
        io.in_data = 64'h0000_0000_0000_0005; io.in_fmt = 2'd1; io.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); io.in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_in_ready", io.in_ready, 1);
        chk("midrst_out_valid", io.out_valid, 0);
        chk("midrst_mant", io.out_mant, 0);
        @(negedge clk); rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("midrst_no_valid", io.out_valid, 0);
        end
        do_op(64'h4009_21FB_5444_2D18, 2'd1, 1);

        for (int k = 0; k < 150; k++) begin
            d = rand_operand(f);
            do_op(d, f, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
